// File: rtl/rom_boot_loader.sv
// UART boot sequencer for the Hack instruction ROM: receives a framed, checksummed
// program image, writes it into the ROM, replies ACK/NAK and gates the CPU reset.
module rom_boot_loader #(
  parameter int          MAX_WORDS   = 32768,
  parameter int          TIMEOUT_CYC = 10000000,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter logic [7:0]  ACK_BYTE    = 8'h06,
  parameter logic [7:0]  NAK_BYTE    = 8'h15,
  parameter bit          AUTOBOOT    = 1'b0
) (
  input  logic        CLK_100MHz,
  input  logic        reset_n,
  input  logic        boot_req,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        rom_we,
  output logic [14:0] rom_addr,
  output logic [15:0] rom_wdata,
  output logic        cpu_hold,
  output logic        boot_active,
  output logic        boot_error
);

  localparam int             TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [16:0]    MAX_N    = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_D_HI, S_D_LO, S_CHECK, S_RESP, S_RUN
  } state_t;

  localparam state_t RST_STATE = AUTOBOOT ? S_IDLE : S_RUN;

  state_t          state;
  logic [7:0]      sum;
  logic [7:0]      len_hi;
  logic [7:0]      hi_byte;
  logic [15:0]     n_words;
  logic [15:0]     idx;
  logic [TW-1:0]   tmo_cnt;
  logic            resp_ack;

  function automatic logic len_bad(input logic [15:0] n);
    return (n == 16'd0) || ({1'b0, n} > MAX_N);
  endfunction

  function automatic logic cks_ok(input logic [7:0] s, input logic [7:0] b);
    logic [7:0] t;
    t = s + b;
    return t == 8'd0;
  endfunction

  always_ff @(posedge CLK_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RST_STATE;
      sum         <= '0;
      len_hi      <= '0;
      hi_byte     <= '0;
      n_words     <= '0;
      idx         <= '0;
      tmo_cnt     <= '0;
      resp_ack    <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      rom_we      <= 1'b0;
      rom_addr    <= '0;
      rom_wdata   <= '0;
      cpu_hold    <= AUTOBOOT;
      boot_active <= AUTOBOOT;
      boot_error  <= 1'b0;
    end else begin
      rom_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state   <= S_LEN_HI;
            sum     <= '0;
            idx     <= '0;
            tmo_cnt <= '0;
          end
        end

        S_LEN_HI, S_LEN_LO, S_D_HI, S_D_LO, S_CHECK: begin
          if (rx_valid) begin
            tmo_cnt <= '0;
            sum     <= sum + rx_data;
            case (state)
              S_LEN_HI: begin
                len_hi <= rx_data;
                state  <= S_LEN_LO;
              end
              S_LEN_LO: begin
                // Reject an empty or oversized image before any ROM write happens
                if (len_bad({len_hi, rx_data})) begin
                  state    <= S_RESP;
                  tx_valid <= 1'b1;
                  tx_data  <= NAK_BYTE;
                  resp_ack <= 1'b0;
                end else begin
                  n_words <= {len_hi, rx_data};
                  state   <= S_D_HI;
                end
              end
              S_D_HI: begin
                hi_byte <= rx_data;
                state   <= S_D_LO;
              end
              S_D_LO: begin
                rom_we    <= 1'b1;
                rom_addr  <= idx[14:0];
                rom_wdata <= {hi_byte, rx_data};
                idx       <= idx + 16'd1;
                state     <= (idx + 16'd1 == n_words) ? S_CHECK : S_D_HI;
              end
              default: begin
                state    <= S_RESP;
                tx_valid <= 1'b1;
                resp_ack <= cks_ok(sum, rx_data);
                tx_data  <= cks_ok(sum, rx_data) ? ACK_BYTE : NAK_BYTE;
              end
            endcase
          end else if (tmo_cnt == TMO_LAST) begin
            // Sender went quiet mid-frame: abandon it and report failure
            state    <= S_RESP;
            tx_valid <= 1'b1;
            tx_data  <= NAK_BYTE;
            resp_ack <= 1'b0;
            tmo_cnt  <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_RESP: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (resp_ack) begin
              state       <= S_RUN;
              cpu_hold    <= 1'b0;
              boot_active <= 1'b0;
              boot_error  <= 1'b0;
            end else begin
              state      <= S_IDLE;
              boot_error <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (boot_req) begin
            state       <= S_IDLE;
            cpu_hold    <= 1'b1;
            boot_active <= 1'b1;
          end
        end

        default: state <= RST_STATE;
      endcase
    end
  end

endmodule
